// File: rtl/wbq_pkg.sv
// Shared types and widths for the register-file write-back queue.
// Holds the entry record used by the queue storage and the source-match scan.
package wbq_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wbq_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Write-request channels (load unit and ALU) into the write-back queue.
// The master drives valid/rd/data; the queue (slave) answers with ready.
interface wb_write_queue_if;
  import wbq_pkg::*;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    input  ld_ready, alu_ready
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    output ld_ready, alu_ready
  );

endinterface

// File: rtl/wbq_match.sv
// Compares one decode-stage source index against every occupied queue entry.
// With WBQ_FWD_EN defined it also returns the data of the youngest matching entry.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_ADDR_W-1:0]  rs,
  input  logic [REG_ADDR_W-1:0]  rd_arr [DEPTH],
  input  logic [DEPTH-1:0]       occupied,
`ifdef WBQ_FWD_EN
  input  logic [XLEN-1:0]        data_arr [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic [XLEN-1:0]        fwd_data,
`endif
  output logic                   busy
);

`ifdef WBQ_FWD_EN
  localparam int PTR_W = $clog2(DEPTH);

  // Walk oldest to youngest so the last hit left standing is the youngest writer.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    busy     = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (occupied[idx] && (rd_arr[idx] == rs)) begin
        busy     = 1'b1;
        fwd_data = data_arr[idx];
      end
    end
    if (rs == '0) busy = 1'b0;
  end
`else
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (rd_arr[i] == rs)) busy = 1'b1;
    end
    if (rs == '0) busy = 1'b0;
  end
`endif

endmodule

// File: rtl/wb_write_queue.sv
// Circular write-back queue merging load and ALU results into one register-file port.
// Define WBQ_FWD_EN to add fwd_data1/fwd_data2 (youngest queued data per source).
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_write_queue_if.slave       req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
`ifdef WBQ_FWD_EN
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t            mem [DEPTH];
  logic [DEPTH-1:0]      occupied;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      alu_slot;
  logic                  ld_enq;
  logic                  alu_enq;
  logic                  deq;
  logic [CNT_W-1:0]      enq_n;
  logic [REG_ADDR_W-1:0] rd_arr [DEPTH];

  // Readiness looks only at the registered count; a retiring head is not credited.
  assign req.ld_ready  = int'(count) < DEPTH;
  assign req.alu_ready = req.ld_valid ? (int'(count) + 2 <= DEPTH)
                                      : (int'(count) + 1 <= DEPTH);

  // rd = 0 requests complete the handshake but never occupy a slot.
  assign ld_enq   = req.ld_valid  && req.ld_ready  && (req.ld_rd  != '0);
  assign alu_enq  = req.alu_valid && req.alu_ready && (req.alu_rd != '0);
  assign enq_n    = CNT_W'(ld_enq) + CNT_W'(alu_enq);
  assign alu_slot = tail + PTR_W'(ld_enq);
  assign deq      = (count != '0);

  assign rf_we    = deq;
  assign rf_waddr = mem[head].rd;
  assign rf_wdata = mem[head].data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      occupied <= '0;
    end else begin
      // NOTE: non-blocking updates let the clear below be overridden by a later set in the same edge.
      if (deq) begin
        occupied[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (ld_enq)  occupied[tail]     <= 1'b1;
      if (alu_enq) occupied[alu_slot] <= 1'b1;
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - CNT_W'(deq);
    end
  end

  // NOTE: entry storage has no reset; occupied/count already mark every slot empty.
  always_ff @(posedge clk) begin
    if (ld_enq)  mem[tail]     <= '{rd: req.ld_rd,  data: req.ld_data};
    if (alu_enq) mem[alu_slot] <= '{rd: req.alu_rd, data: req.alu_data};
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) rd_arr[i] = mem[i].rd;
  end

`ifdef WBQ_FWD_EN
  logic [XLEN-1:0] data_arr [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) data_arr[i] = mem[i].data;
  end

  wbq_match #(.DEPTH(DEPTH)) u_match_rs1 (
    .rs       (rs1),
    .rd_arr   (rd_arr),
    .occupied (occupied),
    .data_arr (data_arr),
    .head     (head),
    .fwd_data (fwd_data1),
    .busy     (busy_rs1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_rs2 (
    .rs       (rs2),
    .rd_arr   (rd_arr),
    .occupied (occupied),
    .data_arr (data_arr),
    .head     (head),
    .fwd_data (fwd_data2),
    .busy     (busy_rs2)
  );
`else
  wbq_match #(.DEPTH(DEPTH)) u_match_rs1 (
    .rs       (rs1),
    .rd_arr   (rd_arr),
    .occupied (occupied),
    .busy     (busy_rs1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_rs2 (
    .rs       (rs2),
    .rd_arr   (rd_arr),
    .occupied (occupied),
    .busy     (busy_rs2)
  );
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic [2:0]  count;
`ifdef WBQ_FWD_EN
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  wb_write_queue_if bus ();

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
`ifdef WBQ_FWD_EN
    .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2),
`endif
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } model_ent_t;

  model_ent_t model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
  endtask

  // One clock of stimulus: apply inputs, compare every output with the model, then advance.
  task automatic cycle(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output logic l_acc, output logic a_acc);
    int free;
    logic eb1, eb2;
    logic [31:0] ef1, ef2;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldat;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    rs1 = r1;
    rs2 = r2;
    #1;
    free = DEPTH - model_q.size();
    check("ld_ready", 32'(bus.ld_ready), 32'(free >= 1));
    check("alu_ready", 32'(bus.alu_ready), 32'(lv ? free >= 2 : free >= 1));
    check("count", 32'(count), 32'(model_q.size()));
    check("rf_we", 32'(rf_we), 32'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      check("rf_waddr", 32'(rf_waddr), 32'(model_q[0].rd));
      check("rf_wdata", rf_wdata, model_q[0].data);
    end
    eb1 = 1'b0; eb2 = 1'b0; ef1 = '0; ef2 = '0;
    foreach (model_q[i]) begin
      if (model_q[i].rd == r1) begin eb1 = (r1 != 0); ef1 = model_q[i].data; end
      if (model_q[i].rd == r2) begin eb2 = (r2 != 0); ef2 = model_q[i].data; end
    end
    check("busy_rs1", 32'(busy_rs1), 32'(eb1));
    check("busy_rs2", 32'(busy_rs2), 32'(eb2));
`ifdef WBQ_FWD_EN
    if (eb1) check("fwd_data1", fwd_data1, ef1);
    if (eb2) check("fwd_data2", fwd_data2, ef2);
`endif
    if (rf_we === 1'b1) wr_seen++;
    l_acc = lv && (free >= 1);
    a_acc = av && (lv ? free >= 2 : free >= 1);
    @(posedge clk);
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (l_acc && lrd != 0) model_q.push_back('{lrd, ldat});
    if (a_acc && ard != 0) model_q.push_back('{ard, adat});
    #1;
  endtask

  typedef struct {
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        we;  logic [4:0] wa;  logic [31:0] wd;
    int          cnt;
    logic        b1;  logic b2; logic lr; logic ar;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic la, aa;
    int ld_idx, alu_idx, wr_start;

    // Rows are applied from an empty queue, one per cycle; outputs are those seen before the edge.
    vecs[0]  = '{0,0,0,            0,0,0,            5,0, 0,0,0,            0, 0,0, 1,1};
    vecs[1]  = '{0,0,0,            1,5,32'hDEADBEEF, 5,0, 0,0,0,            0, 0,0, 1,1};
    vecs[2]  = '{0,0,0,            0,0,0,            5,0, 1,5,32'hDEADBEEF, 1, 1,0, 1,1};
    vecs[3]  = '{0,0,0,            0,0,0,            5,0, 0,0,0,            0, 0,0, 1,1};
    vecs[4]  = '{1,3,32'h11,       1,4,32'h22,       3,4, 0,0,0,            0, 0,0, 1,1};
    vecs[5]  = '{0,0,0,            0,0,0,            3,4, 1,3,32'h11,       2, 1,1, 1,1};
    vecs[6]  = '{0,0,0,            0,0,0,            3,4, 1,4,32'h22,       1, 0,1, 1,1};
    vecs[7]  = '{0,0,0,            1,0,32'h55,       0,0, 0,0,0,            0, 0,0, 1,1};
    vecs[8]  = '{0,0,0,            0,0,0,            0,0, 0,0,0,            0, 0,0, 1,1};
    vecs[9]  = '{1,0,32'h77,       1,9,32'h99,       9,0, 0,0,0,            0, 0,0, 1,1};
    vecs[10] = '{0,0,0,            0,0,0,            9,0, 1,9,32'h99,       1, 1,0, 1,1};
    vecs[11] = '{0,0,0,            0,0,0,            9,0, 0,0,0,            0, 0,0, 1,1};

    drive_idle();
    rs1 = '0;
    rs2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_ld_ready", 32'(bus.ld_ready), 1);
    check("post_rst_alu_ready", 32'(bus.alu_ready), 1);

    // Directed vector table.
    for (int v = 0; v < 12; v++) begin
      bus.ld_valid  = vecs[v].lv;
      bus.ld_rd     = vecs[v].lrd;
      bus.ld_data   = vecs[v].ld;
      bus.alu_valid = vecs[v].av;
      bus.alu_rd    = vecs[v].ard;
      bus.alu_data  = vecs[v].ad;
      rs1 = vecs[v].r1;
      rs2 = vecs[v].r2;
      #1;
      check($sformatf("vec%0d_rf_we", v), 32'(rf_we), 32'(vecs[v].we));
      if (vecs[v].we) begin
        check($sformatf("vec%0d_rf_waddr", v), 32'(rf_waddr), 32'(vecs[v].wa));
        check($sformatf("vec%0d_rf_wdata", v), rf_wdata, vecs[v].wd);
      end
      check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].cnt));
      check($sformatf("vec%0d_busy_rs1", v), 32'(busy_rs1), 32'(vecs[v].b1));
      check($sformatf("vec%0d_busy_rs2", v), 32'(busy_rs2), 32'(vecs[v].b2));
      check($sformatf("vec%0d_ld_ready", v), 32'(bus.ld_ready), 32'(vecs[v].lr));
      check($sformatf("vec%0d_alu_ready", v), 32'(bus.alu_ready), 32'(vecs[v].ar));
      step();
    end
    drive_idle();

    // Six ALU requests back to back while a load stream competes for slots.
    ld_idx = 0;
    alu_idx = 0;
    wr_start = wr_seen;
    for (int c = 0; c < 60 && (ld_idx < 6 || alu_idx < 6); c++) begin
      cycle(ld_idx < 6, 5'(10 + ld_idx), 32'h1000 + 32'(ld_idx),
            alu_idx < 6, 5'(20 + alu_idx), 32'h2000 + 32'(alu_idx),
            5'(20 + alu_idx), 5'(10 + ld_idx), la, aa);
      if (la) ld_idx++;
      if (aa) alu_idx++;
    end
    check("burst_alu_accepted", 32'(alu_idx), 6);
    check("burst_ld_accepted", 32'(ld_idx), 6);
    for (int c = 0; c < 10; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0, la, aa);
    check("burst_writes", 32'(wr_seen - wr_start), 12);

    // Reset in the middle of traffic with three entries queued.
    cycle(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, la, aa);
    cycle(1, 6, 32'h66, 1, 7, 32'h77, 6, 7, la, aa);
    check("pre_rst_count", 32'(count), 3);
    drive_idle();
    rs1 = 5'd6;
    rs2 = 5'd7;
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_rf_we", 32'(rf_we), 0);
    check("mid_rst_busy_rs1", 32'(busy_rs1), 0);
    check("mid_rst_busy_rs2", 32'(busy_rs2), 0);
    model_q.delete();
    step();
    step();
    rst = 1'b0;
    wr_start = wr_seen;
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0, 0, 0, 6, 7, la, aa);
    check("post_rst_writes", 32'(wr_seen - wr_start), 0);

`ifdef WBQ_FWD_EN
    // Two queued writers of the same register: the younger one forwards.
    cycle(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, la, aa);
    rs1 = 5'd7;
    #1;
    check("fwd_youngest", fwd_data1, 32'h2);
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0, la, aa);
`endif

    // Randomized traffic against the reference queue.
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), la, aa);
    end
    for (int c = 0; c < 6; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0, la, aa);
    check("final_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ld_valid/ld_ready  input/output  1/1  load-unit write-request handshake.
REQ-005 SHALL have ports ld_rd/ld_data  input  5/32  load destination register and data.
REQ-006 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU write-request handshake.
REQ-007 SHALL have ports alu_rd/alu_data  input  5/32  ALU destination register and data.
REQ-008 SHALL have ports rf_we/rf_waddr/rf_wdata  output  1/5/32  register-file write port (write enable, write_reg, data_in).
REQ-009 SHALL have ports rs1/rs2  input  5/5  decode-stage source register indices.
REQ-010 SHALL have ports busy_rs1/busy_rs2  output  1/1  source has a queued, unretired write.
REQ-011 SHALL have output count, width clog2(DEPTH)+1, meaning current occupied entries.

Function
REQ-012 SHALL store entries {rd, data} in a circular FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-013 SHALL transfer a request on a rising edge only when valid and ready are both high.
REQ-014 SHALL drive ld_ready high iff count < DEPTH, computed from registered count only (no same-cycle dequeue credit).
REQ-015 SHALL drive alu_ready high iff free slots ≥ 2 when ld_valid is high, else free slots ≥ 1.
REQ-016 SHALL, on simultaneous accepted requests, enqueue the load entry first, then the ALU entry (program order).
REQ-017 SHALL accept requests with rd = 0 and discard them without enqueueing; ready for such a request follows REQ-014/015 unchanged.
REQ-018 SHALL drive rf_we high combinationally whenever count > 0, with rf_waddr/rf_wdata from the head entry; head retires on that clock edge.
REQ-019 SHALL produce minimum latency of one cycle: request accepted at edge N appears on rf_we during the cycle after N and is written at edge N+1.
REQ-020 SHALL support enqueue of up to two and dequeue of one in the same cycle; count updates by (enqueued − dequeued).
REQ-021 SHALL drive busy_rsX high iff some occupied entry has rd equal to rsX and rsX ≠ 0; busy_rsX is low for rs = 0.
REQ-022 SHALL never overflow: full queue holds both readies low; entries drain at one per cycle.

Reset
REQ-023 SHALL, while rst is high, clear head, tail, and count to 0, entry-valid state to empty, and hold rf_we, busy_rs1, busy_rs2 low, with ld_ready and alu_ready high after release.
REQ-024 SHALL discard all queued entries on reset assertion mid-operation; no rf_we pulse occurs for them.

Configuration
REQ-025 SHALL, with macro WBQ_FWD_EN defined, add outputs fwd_data1/fwd_data2 (32 bits) carrying data of the youngest occupied entry matching rs1/rs2.
REQ-026 SHALL, without WBQ_FWD_EN, omit those ports and forwarding logic; busy outputs unchanged.

Structure
REQ-027 SHALL place the entry typedef {rd[4:0], data[31:0]}, REG_ADDR_W = 5, XLEN = 32 in shared package wbq_pkg.
REQ-028 SHALL implement source matching (busy/youngest-match scan) in sub-module wbq_match, instantiated once per source port.

Verification
REQ-029 SHALL verify: ALU write rd=5, data=0xDEADBEEF on edge 1 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the following cycle; busy_rs1=1 for rs1=5 until edge 2.
REQ-030 SHALL verify: ld rd=3/0x11 and alu rd=4/0x22 in the same cycle, empty queue → writes retire in order 3 then 4 on consecutive cycles.
REQ-031 SHALL verify: DEPTH=4, six back-to-back ALU requests with sink stalled-free → ready drops at count=4, no entry lost, six writes in order.
REQ-032 SHALL verify: alu rd=0, data=0x55 → accepted, count stays 0, no rf_we.
REQ-033 SHALL verify: rst asserted with count=3 → count=0, rf_we=0 immediately, no further writes after release.
REQ-034 SHALL verify (WBQ_FWD_EN): entries rd=7/0x1, then rd=7/0x2 queued → fwd_data1=0x2 for rs1=7.
